timer_multi: RTL and testbench

- Parametrised successor to the control-panel system timer.
- Generates the periodic "zegar" clock interrupt with a period selected at run time from the five standard jumper settings (2/4/8/10/20 ms), not fixed at elaboration.
- Adds a latched interrupt request with acknowledge handshake, overrun detection, a saturating missed-tick counter and a synchronous restart.
- Sits in the control panel and feeds the interrupt system.

---
 rtl/timer_multi.sv | 81 ++++++++
 tb/tb_timer_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: run-time selectable periodic zegar tick with latched irq, ack handshake and overrun tracking
module timer_multi #(
    parameter int         CLK_SYS_HZ  = 50_000_000,
    parameter logic [2:0] DEFAULT_SEL = 3'd3,
    parameter int         MISS_W      = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        sel,
    input  logic              restart,
    input  logic              irq_ack,
    input  logic              ovr_clr,
    output logic              zegar,
    output logic              irq,
    output logic              overrun,
    output logic [MISS_W-1:0] miss_cnt,
    output logic [4:0]        period_ms
);
    localparam int P = CLK_SYS_HZ / 1000;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(P - 1);

    function automatic logic [4:0] decode(input logic [2:0] s);
        return s == 3'd0 ? 5'd2 : s == 3'd1 ? 5'd4 : s == 3'd2 ? 5'd8 : s == 3'd3 ? 5'd10 : 5'd20;
    endfunction

    localparam logic [4:0] DEF_PERIOD = decode(DEFAULT_SEL);

    logic [PW-1:0] pre_cnt;
    logic [4:0]    ms_cnt;
    logic [4:0]    period_q;
    logic [4:0]    sel_period;
    logic          ms_tick;
    logic          wrap;
    logic          ovr_event;

    assign sel_period = decode(sel);
    assign ms_tick    = pre_cnt == '0;
    assign wrap       = ms_tick & (ms_cnt == 5'd0);
    assign zegar      = enable & wrap & ~restart;
    assign ovr_event  = zegar & irq & ~irq_ack;
    assign period_ms  = period_q;

    // Free-running ms prescaler and period counter; a new sel is only adopted at a wrap or restart
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= P_LAST;
            ms_cnt   <= DEF_PERIOD - 5'd1;
            period_q <= DEF_PERIOD;
        end else if (restart) begin
            pre_cnt  <= P_LAST;
            ms_cnt   <= sel_period - 5'd1;
            period_q <= sel_period;
        end else begin
            pre_cnt <= ms_tick ? P_LAST : pre_cnt - PW'(1);
            if (ms_tick) begin
                ms_cnt   <= ms_cnt == 5'd0 ? sel_period - 5'd1 : ms_cnt - 5'd1;
                period_q <= ms_cnt == 5'd0 ? sel_period : period_q;
            end
        end
    end

    // Interrupt latch and overrun bookkeeping; a fresh tick beats both ack and clear
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            irq      <= 1'b0;
            overrun  <= 1'b0;
            miss_cnt <= '0;
        end else begin
            irq <= zegar ? 1'b1 : irq_ack ? 1'b0 : irq;
            if (ovr_event) begin
                overrun  <= 1'b1;
                miss_cnt <= ovr_clr ? MISS_W'(1) : (&miss_cnt) ? miss_cnt : miss_cnt + MISS_W'(1);
            end else if (ovr_clr) begin
                overrun  <= 1'b0;
                miss_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: table vectors, random stimulus vs time-based model, and async reset check for timer_multi
module tb_timer_multi;
    localparam int P = 4;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       restart = 1'b0;
    logic       irq_ack = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       zegar;
    logic       irq;
    logic       overrun;
    logic [1:0] miss_cnt;
    logic [4:0] period_ms;

    int n_vec = 0;
    int n_bad = 0;

    int   m_cyc;
    int   m_nxt;
    int   m_n;
    int   m_miss;
    logic m_irq;
    logic m_ovr;
    logic m_z;

    typedef struct {
        int         w;
        logic       en;
        logic [2:0] s;
        logic       rs;
        logic       ak;
        logic       cl;
        logic       z;
        logic       i;
        logic       o;
        logic [1:0] m;
        logic [4:0] p;
    } vec_t;

    vec_t tbl[$];

    timer_multi #(.CLK_SYS_HZ(4000), .DEFAULT_SEL(3'd0), .MISS_W(2)) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .enable(enable),
        .sel(sel),
        .restart(restart),
        .irq_ack(irq_ack),
        .ovr_clr(ovr_clr),
        .zegar(zegar),
        .irq(irq),
        .overrun(overrun),
        .miss_cnt(miss_cnt),
        .period_ms(period_ms)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int dec(input logic [2:0] s);
        int t[5] = '{2, 4, 8, 10, 20};
        return s > 3'd4 ? 20 : t[int'(s)];
    endfunction

    function automatic logic [9:0] outs();
        return {zegar, irq, overrun, miss_cnt, period_ms};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got z/i/o/m/p=%b want %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_n    = dec(3'd0);
        m_nxt  = m_n * P - 1;
        m_irq  = 1'b0;
        m_ovr  = 1'b0;
        m_miss = 0;
    endtask

    task automatic drive(input logic en, input logic [2:0] s, input logic rs, input logic ak,
                         input logic cl, input string nm);
        enable  = en;
        sel     = s;
        restart = rs;
        irq_ack = ak;
        ovr_clr = cl;
        #1;
        m_z = en && (m_cyc == m_nxt) && !rs;
        chk(nm, outs(), {m_z, m_irq, m_ovr, 2'(m_miss), 5'(m_n)});
    endtask

    task automatic advance();
        @(posedge clk_sys);
        if (restart || m_cyc == m_nxt) begin
            m_n   = dec(sel);
            m_nxt = m_cyc + m_n * P;
        end
        if (m_z && m_irq && !irq_ack) begin
            m_ovr  = 1'b1;
            m_miss = ovr_clr ? 1 : (m_miss < 3 ? m_miss + 1 : 3);
        end else if (ovr_clr) begin
            m_ovr  = 1'b0;
            m_miss = 0;
        end
        if (m_z) m_irq = 1'b1;
        else if (irq_ack) m_irq = 1'b0;
        m_cyc++;
        @(negedge clk_sys);
    endtask

    task automatic add(input int w, input logic en, input logic [2:0] s, input logic rs, input logic ak,
                       input logic cl, input logic z, input logic i, input logic o, input logic [1:0] m,
                       input logic [4:0] p);
        tbl.push_back('{w, en, s, rs, ak, cl, z, i, o, m, p});
    endtask

    initial begin
        add(0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(6,  1, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(3,  1, 0, 0, 1, 0, 0, 1, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1,  1, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(6,  1, 0, 0, 1, 0, 1, 1, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(6,  1, 0, 0, 0, 0, 1, 1, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 1, 2);
        add(6,  1, 0, 0, 0, 0, 1, 1, 1, 1, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 2, 2);
        add(6,  1, 0, 0, 0, 0, 1, 1, 1, 2, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(6,  1, 0, 0, 0, 0, 1, 1, 1, 3, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(0,  1, 0, 0, 0, 1, 0, 1, 1, 3, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(4,  1, 0, 0, 0, 1, 1, 1, 0, 0, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 1, 2);
        add(1,  1, 4, 0, 0, 0, 0, 1, 1, 1, 2);
        add(4,  1, 4, 0, 0, 0, 1, 1, 1, 1, 2);
        add(0,  1, 4, 0, 0, 0, 0, 1, 1, 2, 20);
        add(78, 1, 6, 0, 0, 0, 1, 1, 1, 2, 20);
        add(0,  1, 6, 0, 0, 0, 0, 1, 1, 3, 20);
        add(78, 1, 6, 0, 1, 0, 1, 1, 1, 3, 20);
        add(76, 1, 0, 1, 0, 0, 0, 1, 1, 3, 20);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(1,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(3,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(0,  1, 0, 0, 0, 0, 1, 1, 1, 3, 2);
        add(7,  1, 0, 1, 0, 0, 0, 1, 1, 3, 2);
        add(7,  1, 0, 0, 0, 0, 1, 1, 1, 3, 2);
        add(0,  0, 0, 0, 0, 0, 0, 1, 1, 3, 2);
        add(0,  0, 0, 0, 1, 0, 0, 1, 1, 3, 2);
        add(5,  0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
        add(15, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
        add(7,  1, 0, 0, 0, 0, 1, 0, 1, 3, 2);
        add(0,  1, 0, 0, 0, 0, 0, 1, 1, 3, 2);

        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].w; k++) begin
                drive(tbl[i].en, tbl[i].s, 1'b0, 1'b0, 1'b0, "tbl_wait_model");
                advance();
            end
            drive(tbl[i].en, tbl[i].s, tbl[i].rs, tbl[i].ak, tbl[i].cl, "tbl_model");
            chk($sformatf("tbl[%0d]", i), outs(), {tbl[i].z, tbl[i].i, tbl[i].o, tbl[i].m, tbl[i].p});
            advance();
        end

        begin
            logic [2:0] rs_sel = 3'd0;
            for (int k = 0; k < 1500; k++) begin
                if ($urandom_range(0, 49) == 0) rs_sel = 3'($urandom_range(0, 7));
                drive($urandom_range(0, 9) != 0, rs_sel, $urandom_range(0, 59) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, "rand_model");
                advance();
            end
        end

        drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, "pre_rst_model");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), {1'b0, 1'b0, 1'b0, 2'd0, 5'd2});
        @(negedge clk_sys);
        chk("rst_held", outs(), {1'b0, 1'b0, 1'b0, 2'd0, 5'd2});
        rst_n = 1'b1;
        sel = 3'd0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst_model");
            if (k == 7) chk("post_rst_tick", outs(), {1'b1, 1'b0, 1'b0, 2'd0, 5'd2});
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
